// File: rtl/dt_pkg.sv
// Shared types for the decision-tree walker: node word layout, FSM states
// and the decoded-node struct.
package dt_pkg;

    localparam int ID_W    = 12;
    localparam int TYPE_W  = 4;
    localparam int FIDX_W  = 4;
    localparam int THR_W   = 32;
    localparam int RSVD_W  = 40;
    localparam int PTR_W   = 12;
    localparam int CLASS_W = 4;
    localparam int NODE_W  = ID_W + TYPE_W + FIDX_W + THR_W + RSVD_W + 2 * PTR_W + CLASS_W;

    localparam logic [TYPE_W-1:0] NODE_TYPE_LEAF = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        DONE,
        ERR
    } state_t;

    // Field order matches the ROM word, MSB first, so a straight cast unpacks it.
    typedef struct packed {
        logic [ID_W-1:0]    node_id;
        logic [TYPE_W-1:0]  node_type;
        logic [FIDX_W-1:0]  feature_idx;
        logic [THR_W-1:0]   threshold;
        logic [RSVD_W-1:0]  rsvd;
        logic [PTR_W-1:0]   left;
        logic [PTR_W-1:0]   right;
        logic [CLASS_W-1:0] leaf_class;
    } node_t;

endpackage

// File: rtl/dt_node_decode.sv
// Combinational node unpacker: field split, signed threshold compare,
// child select and the per-node legality flags.
module dt_node_decode
    import dt_pkg::*;
#(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int ROM_DEPTH    = 512,
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_WIDTH   = 32
) (
    input  logic [NODE_WIDTH-1:0]              word,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features,
    output logic                               is_leaf,
    output logic [ADDR_WIDTH-1:0]              next_addr,
    output logic [CLASS_W-1:0]                 leaf_class,
    output logic                               id_bad,
    output logic                               feat_bad,
    output logic                               child_bad
);

    node_t                  node;
    logic [FEAT_WIDTH-1:0]  feat_sel;
    logic [PTR_W-1:0]       child;
    logic                   unused_rsvd;

    always_comb begin
        node       = node_t'(word);
        feat_sel   = features[int'(node.feature_idx) * FEAT_WIDTH +: FEAT_WIDTH];
        // Equality goes left.
        child      = ($signed(feat_sel) <= $signed(node.threshold)) ? node.left : node.right;
        is_leaf    = (node.node_type == NODE_TYPE_LEAF);
        leaf_class = node.leaf_class;
        id_bad     = (node.node_id != {{(PTR_W - ADDR_WIDTH){1'b0}}, addr});
        feat_bad   = (int'(node.feature_idx) >= NUM_FEATURES);
        child_bad  = (int'(child) >= ROM_DEPTH);
        next_addr  = child[ADDR_WIDTH-1:0];
    end

    assign unused_rsvd = ^node.rsvd;

endmodule

// File: rtl/dt_tree_walker.sv
// Walks one decision tree held in an external registered-output ROM, two
// cycles per node, and returns the leaf class through a valid/ready port.
module dt_tree_walker
    import dt_pkg::*;
#(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int ROM_DEPTH    = 512,
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_WIDTH   = 32,
    parameter int MAX_DEPTH    = 32,
    parameter int ROOT_ADDR    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] in_features,
    output logic [ADDR_WIDTH-1:0]              rom_addr,
    input  logic [NODE_WIDTH-1:0]              rom_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [3:0]                         out_class,
    output logic                               out_error,
    output logic [5:0]                         out_depth
);

    state_t                            state_q, state_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [5:0]                        depth_q, depth_d;
    logic [3:0]                        class_q, class_d;
    logic [NUM_FEATURES*FEAT_WIDTH-1:0] feat_q;
    logic                              load_feat;

    logic                  is_leaf, id_bad, feat_bad, child_bad;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CLASS_W-1:0]    leaf_class;

    dt_node_decode #(
        .NODE_WIDTH  (NODE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ROM_DEPTH   (ROM_DEPTH),
        .NUM_FEATURES(NUM_FEATURES),
        .FEAT_WIDTH  (FEAT_WIDTH)
    ) u_decode (
        .word      (rom_data),
        .addr      (addr_q),
        .features  (feat_q),
        .is_leaf   (is_leaf),
        .next_addr (next_addr),
        .leaf_class(leaf_class),
        .id_bad    (id_bad),
        .feat_bad  (feat_bad),
        .child_bad (child_bad)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        depth_d   = depth_q;
        class_d   = class_q;
        load_feat = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_feat = 1'b1;
                    addr_d    = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d   = '0;
                    state_d   = READ;
                end
            end
            READ: state_d = EVAL;
            EVAL: begin
                // depth_d counts the node under evaluation.
                depth_d = depth_q + 6'd1;
                if (id_bad || feat_bad || (depth_d > 6'(MAX_DEPTH))) begin
                    class_d = '0;
                    state_d = ERR;
                end else if (is_leaf) begin
                    class_d = leaf_class;
                    state_d = DONE;
                end else if (child_bad) begin
                    class_d = '0;
                    state_d = ERR;
                end else begin
                    addr_d  = next_addr;
                    state_d = READ;
                end
            end
            DONE, ERR: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= ADDR_WIDTH'(ROOT_ADDR);
            depth_q <= '0;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            depth_q <= depth_d;
            class_q <= class_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_feat) feat_q <= in_features;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE) || (state_q == ERR);
    assign out_error = (state_q == ERR);
    assign out_class = class_q;
    assign out_depth = depth_q;
    assign rom_addr  = addr_q;

endmodule

// File: tb/tb_dt_tree_walker.sv
// Self-checking bench for dt_tree_walker: directed tree walks, corner cases
// and a random ROM checked against a software tree model.
module tb_dt_tree_walker;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_features;
    logic [9:0]   rom_addr;
    logic [119:0] rom_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_class;
    logic         out_error;
    logic [5:0]   out_depth;

    logic [119:0] rom [1024];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           lat;
    logic [9:0]   trace[$];

    dt_tree_walker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_features(in_features),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_error  (out_error),
        .out_depth  (out_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic signed [31:0] f2;
        logic signed [31:0] f0;
        logic [3:0]         cls;
        logic [5:0]         dep;
        int                 lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [119:0] mk(input int id, input int typ, input int fidx,
                                        input logic [31:0] thr, input int l, input int r,
                                        input int c);
        return {12'(id), 4'(typ), 4'(fidx), thr, 40'b0, 12'(l), 12'(r), 4'(c)};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    task automatic tree_a();
        clear_rom();
        rom[0] = mk(0, 0, 2, 32'sd100, 1, 2, 0);
        rom[1] = mk(1, 3, 0, 0, 0, 0, 2);
        rom[2] = mk(2, 1, 0, -32'sd5, 5, 6, 0);
        rom[5] = mk(5, 3, 0, 0, 0, 0, 0);
        rom[6] = mk(6, 3, 0, 0, 0, 0, 1);
    endtask

    // Called at posedge+1 with the walker idle; returns once out_valid is seen.
    task automatic start_walk(input logic [511:0] feats);
        in_features = feats;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_features = ~feats;
        trace.delete();
        trace.push_back(rom_addr);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (rom_addr != trace[$]) trace.push_back(rom_addr);
        end
        if (!out_valid) chk("timeout", out_valid, 1);
    endtask

    task automatic end_walk();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", in_ready, 1);
        chk("out_valid_after_handshake", out_valid, 0);
    endtask

    task automatic walk_check(input string name, input logic [511:0] feats, input logic [3:0] cls,
                              input logic err, input logic [5:0] dep, input int exp_lat);
        start_walk(feats);
        chk({name, "_class"}, out_class, cls);
        chk({name, "_error"}, out_error, err);
        chk({name, "_depth"}, out_depth, dep);
        chk({name, "_latency"}, lat, exp_lat);
        end_walk();
    endtask

    function automatic logic [511:0] feat2_0(input logic [31:0] f2, input logic [31:0] f0);
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom;
        f[64 +: 32] = f2;
        f[0 +: 32]  = f0;
        return f;
    endfunction

    // Reference: follow the tree in the ROM array directly from the node rules.
    function automatic void model(input logic [511:0] f, output logic [3:0] c,
                                  output logic e, output int d);
        int                 a;
        logic [119:0]       w;
        logic signed [31:0] fv, th;
        logic [11:0]        ch;
        a = 0; c = '0; e = 1'b0; d = 0;
        for (int k = 0; k < 40; k++) begin
            w = rom[a];
            d++;
            if (w[119:108] != 12'(a) || d > 32 || int'(w[103:100]) >= 16) begin
                e = 1'b1;
                return;
            end
            if (w[107:104] == 4'h3) begin
                c = w[3:0];
                return;
            end
            fv = f[int'(w[103:100]) * 32 +: 32];
            th = w[99:68];
            ch = (fv <= th) ? w[27:16] : w[15:4];
            if (ch >= 12'd512) begin
                e = 1'b1;
                return;
            end
            a = int'(ch);
        end
    endfunction

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 99) < 80) return 32'($urandom_range(0, 200)) - 32'd100;
        return $urandom;
    endfunction

    task automatic gen_rom();
        int t, l, r, id;
        clear_rom();
        for (int a = 0; a < 512; a++) begin
            id = ($urandom_range(0, 99) == 0) ? (a ^ 1) : a;
            if (a >= 500 || $urandom_range(0, 99) < 25) begin
                rom[a] = mk(id, 3, $urandom_range(0, 15), rnd_val(), 0, 0, $urandom_range(0, 15));
            end else begin
                t = $urandom_range(0, 14);
                if (t >= 3) t++;
                l = $urandom_range(0, 99);
                r = $urandom_range(0, 99);
                l = (l < 3) ? 512 + $urandom_range(0, 3583) : (l < 6) ? $urandom_range(0, a)
                    : ((a + 1 + $urandom_range(0, 15)) > 511 ? 511 : a + 1 + $urandom_range(0, 15));
                r = (r < 3) ? 512 + $urandom_range(0, 3583) : (r < 6) ? $urandom_range(0, a)
                    : ((a + 1 + $urandom_range(0, 15)) > 511 ? 511 : a + 1 + $urandom_range(0, 15));
                rom[a] = mk(id, t, $urandom_range(0, 15), rnd_val(), l, r, $urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        vec_t         vecs[6];
        logic [511:0] f;
        logic [3:0]   m_c;
        logic         m_e;
        int           m_d;
        int           bad;

        vecs[0] = '{32'sd101, -32'sd5, 4'd0, 6'd3, 6};
        vecs[1] = '{32'sd101, -32'sd4, 4'd1, 6'd3, 6};
        vecs[2] = '{32'sd100, 32'sd7, 4'd2, 6'd2, 4};
        vecs[3] = '{32'h8000_0000, 32'sd0, 4'd2, 6'd2, 4};
        vecs[4] = '{32'h7fff_ffff, 32'h8000_0000, 4'd0, 6'd3, 6};
        vecs[5] = '{32'sd200, 32'sd1000, 4'd1, 6'd3, 6};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_features = '0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_class", out_class, 0);
        chk("reset_out_error", out_error, 0);
        chk("reset_out_depth", out_depth, 0);
        chk("reset_rom_addr", rom_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Root-only leaf.
        rom[0] = mk(0, 3, 0, 0, 0, 0, 1);
        walk_check("root_leaf", feat2_0(0, 0), 4'd1, 1'b0, 6'd1, 2);
        chk("root_leaf_trace_len", trace.size(), 1);
        chk("root_leaf_trace0", trace[0], 0);

        // Three-level tree, table driven.
        tree_a();
        for (int i = 0; i < 6; i++) begin
            walk_check($sformatf("tree_a_v%0d", i), feat2_0(vecs[i].f2, vecs[i].f0),
                       vecs[i].cls, 1'b0, vecs[i].dep, vecs[i].lat);
            if (i == 0) begin
                chk("tree_a_v0_trace_len", trace.size(), 3);
                chk("tree_a_v0_trace", {trace[0], trace[1], trace[2]}, {10'd0, 10'd2, 10'd5});
            end else if (i == 1) begin
                chk("tree_a_v1_trace", {trace[0], trace[1], trace[2]}, {10'd0, 10'd2, 10'd6});
            end
        end

        // Backpressure: result holds, new offers ignored.
        start_walk(feat2_0(32'sd101, -32'sd4));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid    = 1'b1;
            in_features = feat2_0(-32'sd1000, 32'sd1000);
            @(posedge clk); #1;
            if (!(out_valid && out_class == 4'd1 && out_depth == 6'd3 && !out_error &&
                  !in_ready && rom_addr == 10'd6)) bad++;
        end
        in_valid = 1'b0;
        chk("backpressure_stable_bad_cycles", bad, 0);
        end_walk();

        // Error: illegal child pointer.
        clear_rom();
        rom[0] = mk(0, 0, 0, 0, 512, 512, 9);
        walk_check("err_child512", feat2_0(0, 0), 4'd0, 1'b1, 6'd1, 2);

        // Error: node_id mismatch at node 1.
        clear_rom();
        rom[0] = mk(0, 0, 0, 0, 1, 1, 0);
        rom[1] = mk(7, 3, 0, 0, 0, 0, 4);
        walk_check("err_id_node1", feat2_0(0, 0), 4'd0, 1'b1, 6'd2, 4);

        // Error: self loop runs out of depth.
        clear_rom();
        rom[0] = mk(0, 0, 0, 0, 0, 0, 3);
        walk_check("err_self_loop", feat2_0(0, 0), 4'd0, 1'b1, 6'd33, 66);

        // Depth boundary: leaf at exactly 32 passes, at 33 errors.
        clear_rom();
        for (int i = 0; i < 31; i++) rom[i] = mk(i, 0, 0, 0, i + 1, i + 1, 0);
        rom[31] = mk(31, 3, 0, 0, 0, 0, 5);
        walk_check("depth_32_leaf", feat2_0(0, 0), 4'd5, 1'b0, 6'd32, 64);
        rom[31] = mk(31, 0, 0, 0, 32, 32, 0);
        rom[32] = mk(32, 3, 0, 0, 0, 0, 6);
        walk_check("depth_33_leaf", feat2_0(0, 0), 4'd0, 1'b1, 6'd33, 66);

        // Reset while reading node 2 abandons the walk.
        tree_a();
        in_features = feat2_0(32'sd101, -32'sd5);
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midwalk_addr_node2", rom_addr, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midwalk_rst_in_ready", in_ready, 1);
        chk("midwalk_rst_out_valid", out_valid, 0);
        chk("midwalk_rst_rom_addr", rom_addr, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("midwalk_no_result", bad, 0);
        walk_check("after_reset_walk", feat2_0(32'sd101, -32'sd4), 4'd1, 1'b0, 6'd3, 6);

        // Random regression against the tree model.
        gen_rom();
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 16; i++) f[i*32 +: 32] = rnd_val();
            model(f, m_c, m_e, m_d);
            walk_check($sformatf("rand%0d", n), f, m_c, m_e, 6'(m_d), 2 * m_d);
            if (n % 250 == 249) gen_rom();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
